// File: rtl/snake_button_in_pkg.sv
// Shared register-map constants and sizing helper for the snake_button_in block.
// Optional debounce is enabled by defining SNAKE_BUTTON_IN_DEBOUNCE_EN.
package snake_button_in_pkg;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd1;
  localparam logic [1:0] ADDR_RSVD = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  // Counter width for a debounce period; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned cycles);
    int unsigned w;
    w = (cycles > 1) ? $clog2(cycles) : 1;
    return w;
  endfunction

endpackage

// File: rtl/snake_button_debounce.sv
// One-bit debouncer: accepts a new synchronized level only after it has held
// for DEBOUNCE_CYCLES consecutive clocks. Used when SNAKE_BUTTON_IN_DEBOUNCE_EN is defined.
module snake_button_debounce
  import snake_button_in_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic sync_bit,
  output logic level
);

  localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt;

  // Counting only runs while the input disagrees with the accepted level;
  // any return to agreement throws the progress away.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      level <= 1'b1;
    end else if (sync_bit != level) begin
      if (cnt == LAST) begin
        level <= sync_bit;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end else begin
      cnt <= '0;
    end
  end

endmodule

// File: rtl/snake_button_in.sv
// Avalon-MM button input port: synchronizer, press (falling-edge) capture with W1C
// clear, maskable level irq. Define SNAKE_BUTTON_IN_DEBOUNCE_EN to add per-pin debounce.
module snake_button_in
  import snake_button_in_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = 8,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic                  irq
);

  if (DATA_WIDTH < 1 || DATA_WIDTH > 32) begin : g_bad_width
    $error("DATA_WIDTH must be 1..32");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be at least 2");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_deb
    $error("DEBOUNCE_CYCLES must be at least 1");
  end

  logic [DATA_WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [DATA_WIDTH-1:0] sync_in;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_prev;
  logic [DATA_WIDTH-1:0] irq_mask;
  logic [DATA_WIDTH-1:0] edge_capture;
  logic [DATA_WIDTH-1:0] edge_clear;
  logic [DATA_WIDTH-1:0] press;
  logic                  wr_en;
  logic                  unused_wdata;

  assign unused_wdata = ^writedata;

  // Pins idle high (released), so the chain resets to ones to avoid a false press.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < int'(SYNC_STAGES); s++) sync_q[s] <= '1;
    end else begin
      sync_q[0] <= in_port;
      for (int s = 1; s < int'(SYNC_STAGES); s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign sync_in = sync_q[SYNC_STAGES-1];

`ifdef SNAKE_BUTTON_IN_DEBOUNCE_EN
  for (genvar g = 0; g < int'(DATA_WIDTH); g++) begin : g_deb
    snake_button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk      (clk),
      .reset    (reset),
      .sync_bit (sync_in[g]),
      .level    (data_in[g])
    );
  end
`else
  assign data_in = sync_in;
`endif

  assign wr_en      = chipselect & ~write_n;
  assign press      = data_prev & ~data_in;
  assign edge_clear = (wr_en && address == ADDR_EDGE) ? writedata[DATA_WIDTH-1:0] : '0;

  // New presses are OR-ed in after the clear so a same-cycle press survives.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_prev    <= '1;
      irq_mask     <= '0;
      edge_capture <= '0;
      irq          <= 1'b0;
    end else begin
      data_prev    <= data_in;
      edge_capture <= (edge_capture & ~edge_clear) | press;
      irq          <= |(edge_capture & irq_mask);
      if (wr_en && address == ADDR_MASK) irq_mask <= writedata[DATA_WIDTH-1:0];
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA: readdata[DATA_WIDTH-1:0] = data_in;
      ADDR_MASK: readdata[DATA_WIDTH-1:0] = irq_mask;
      ADDR_RSVD: readdata = '0;
      ADDR_EDGE: readdata[DATA_WIDTH-1:0] = edge_capture;
      default:   readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_snake_button_in.sv
// Directed bench for snake_button_in: register map, press capture, W1C, irq masking,
// reset mid-operation and (when SNAKE_BUTTON_IN_DEBOUNCE_EN is defined) debounce.
module tb_snake_button_in;

  localparam int DW  = 8;
  localparam int SS  = 2;
  localparam int DEB = 4;
`ifdef SNAKE_BUTTON_IN_DEBOUNCE_EN
  localparam int LAT = SS + DEB + 1;
`else
  localparam int LAT = SS + 1;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [31:0]   readdata;
  logic [DW-1:0] in_port;
  logic          irq;

  int checks = 0;
  int errors = 0;

  snake_button_in #(
    .DATA_WIDTH      (DW),
    .SYNC_STAGES     (SS),
    .DEBOUNCE_CYCLES (DEB)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .in_port    (in_port),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rd_check(input logic [1:0] a, input logic [31:0] exp, input string tag);
    address = a;
    #1;
    check(tag, readdata, exp);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    tick(1);
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  initial begin
    reset      = 1'b1;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in_port    = 8'hFF;
    tick(3);
    reset = 1'b0;

    // Reset state
    rd_check(2'd0, 32'h0000_00FF, "rst_data");
    rd_check(2'd1, 32'h0, "rst_mask");
    rd_check(2'd3, 32'h0, "rst_edge");
    check("rst_irq", {31'b0, irq}, 32'h0);
    tick(1);
    rd_check(2'd3, 32'h0, "no_edge_after_release");

    // Ignored writes: addr 2, addr 0, and addr 1 without chipselect
    wr(2'd2, 32'hFFFF_FFFF);
    rd_check(2'd2, 32'h0, "rsvd_reads_zero");
    wr(2'd0, 32'h0000_0000);
    rd_check(2'd0, 32'h0000_00FF, "data_ro");
    chipselect = 1'b0; write_n = 1'b0; address = 2'd1; writedata = 32'hFF;
    tick(1);
    write_n = 1'b1; writedata = '0;
    rd_check(2'd1, 32'h0, "mask_needs_cs");

    // Press bit 0 with mask 01: capture after LAT, irq one clk later, W1C clears
    wr(2'd1, 32'hFFFF_FF01);
    rd_check(2'd1, 32'h0000_0001, "mask_load_low_bits");
    in_port = 8'hFE;
    tick(LAT - 1);
    rd_check(2'd3, 32'h0, "b0_edge_not_yet");
    tick(1);
    rd_check(2'd3, 32'h0000_0001, "b0_edge_set");
    check("b0_irq_lags", {31'b0, irq}, 32'h0);
    rd_check(2'd0, 32'h0000_00FE, "b0_data_low");
    tick(1);
    check("b0_irq_set", {31'b0, irq}, 32'h1);
    wr(2'd3, 32'h0000_0001);
    rd_check(2'd3, 32'h0, "b0_edge_cleared");
    check("b0_irq_still_reg", {31'b0, irq}, 32'h1);
    tick(1);
    check("b0_irq_cleared", {31'b0, irq}, 32'h0);
    in_port = 8'hFF;
    tick(LAT + 2);
    rd_check(2'd3, 32'h0, "release_no_capture");
    check("release_no_irq", {31'b0, irq}, 32'h0);

    // Press on bit 2 lands on the same edge as a W1C of bit 2: set wins
    in_port = 8'hFB;
    tick(LAT - 1);
    wr(2'd3, 32'h0000_0004);
    rd_check(2'd3, 32'h0000_0004, "set_beats_clear");
    tick(1);
    check("b2_masked_no_irq", {31'b0, irq}, 32'h0);
    wr(2'd3, 32'h0000_0004);
    rd_check(2'd3, 32'h0, "b2_cleared");
    in_port = 8'hFF;
    tick(LAT + 1);

    // Masked press on bit 5, then unmask raises irq one clk after mask loads
    wr(2'd1, 32'h0000_0000);
    in_port = 8'hDF;
    tick(LAT + 1);
    rd_check(2'd3, 32'h0000_0020, "b5_edge_set");
    check("b5_masked_irq", {31'b0, irq}, 32'h0);
    wr(2'd1, 32'h0000_0020);
    check("b5_irq_lags_mask", {31'b0, irq}, 32'h0);
    tick(1);
    check("b5_irq_after_mask", {31'b0, irq}, 32'h1);
    wr(2'd3, 32'h0000_00DF);
    rd_check(2'd3, 32'h0000_0020, "w1c_other_bits_only");
    wr(2'd3, 32'h0000_0020);
    tick(1);
    check("b5_irq_cleared", {31'b0, irq}, 32'h0);
    in_port = 8'hFF;
    tick(LAT + 1);

`ifdef SNAKE_BUTTON_IN_DEBOUNCE_EN
    // Short glitch is rejected, a held press is accepted
    in_port = 8'hFD;
    tick(DEB - 1);
    in_port = 8'hFF;
    tick(LAT + 2);
    rd_check(2'd3, 32'h0, "deb_glitch_rejected");
    in_port = 8'hFD;
    tick(LAT - 1);
    rd_check(2'd3, 32'h0, "deb_hold_not_yet");
    tick(1);
    rd_check(2'd3, 32'h0000_0002, "deb_hold_accepted");
    wr(2'd3, 32'h0000_0002);
    in_port = 8'hFF;
    tick(LAT + 1);
`endif

    // Reset while a press on bit 3 is still in flight
    wr(2'd1, 32'h0000_0008);
    in_port = 8'hF7;
    tick(LAT - 1);
    reset = 1'b1;
    #1;
    rd_check(2'd0, 32'h0000_00FF, "midrst_data");
    rd_check(2'd1, 32'h0, "midrst_mask");
    rd_check(2'd3, 32'h0, "midrst_edge");
    check("midrst_irq", {31'b0, irq}, 32'h0);
    tick(2);
    reset = 1'b0;
    tick(LAT - 1);
    rd_check(2'd3, 32'h0, "post_rst_not_yet");
    tick(1);
    rd_check(2'd3, 32'h0000_0008, "post_rst_capture");
    wr(2'd3, 32'h0000_0008);
    tick(LAT + 2);
    rd_check(2'd3, 32'h0, "post_rst_single_capture");
    check("post_rst_mask_zero_irq", {31'b0, irq}, 32'h0);
    in_port = 8'hFF;
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
